// File: rtl/mem_access_unit.sv
// Load/store bridge between the core datapath and a req/ack memory port.
// Handles byte-lane steering, word alignment checks and access timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ByteAcc,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AlignErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_mem_req;
  logic            r_we;
  logic            r_byte;
  logic [1:0]      r_lane;
  logic [3:0]      r_be;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_align_err;
  logic            r_bus_err;

  logic            w_access;
  logic            w_misalign;
  logic            w_start;
  logic            w_align;
  logic            w_ack;
  logic            w_tmo;
  logic            w_stall;
  logic [7:0]      w_lane_byte;
  logic [31:0]     w_rd_fmt;

  assign w_access   = MemRead | MemWrite;
  assign w_misalign = !ByteAcc && (Addr[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_align     = 1'b0;
    w_ack       = 1'b0;
    w_tmo       = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_misalign) begin
            w_align = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (mem_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Little-endian lane select for byte loads, using the latched lane
  always_comb begin
    w_lane_byte = mem_rdata[7:0];
    case (r_lane)
      2'd0:    w_lane_byte = mem_rdata[7:0];
      2'd1:    w_lane_byte = mem_rdata[15:8];
      2'd2:    w_lane_byte = mem_rdata[23:16];
      default: w_lane_byte = mem_rdata[31:24];
    endcase
  end

  assign w_rd_fmt = r_byte ? {24'd0, w_lane_byte} : mem_rdata;

  // Request latching, timeout counter, read capture and error pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_lane      <= 2'd0;
      r_be        <= 4'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rdata     <= 32'd0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_align_err <= w_align;
      r_bus_err   <= w_tmo;

      if (w_start) begin
        r_mem_req <= 1'b1;
        r_addr    <= {Addr[31:2], 2'b00};
        r_we      <= MemWrite;
        r_byte    <= ByteAcc;
        r_lane    <= Addr[1:0];
        r_be      <= ByteAcc ? 4'(4'b0001 << Addr[1:0]) : 4'b1111;
        r_wdata   <= ByteAcc ? {4{WriteData[7:0]}} : WriteData;
      end else if (w_ack || w_tmo) begin
        r_mem_req <= 1'b0;
      end

      if (r_state == S_REQ && !w_ack && !w_tmo) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end

      // Writes and aborted/rejected accesses return zero
      if (w_ack) begin
        r_rdata <= r_we ? 32'd0 : w_rd_fmt;
      end else if (w_tmo || w_align) begin
        r_rdata <= 32'd0;
      end
    end
  end

  // Stall must fall with reset even while a request is still presented
  assign Stall     = reset & w_stall;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign ReadData  = r_rdata;
  assign AlignErr  = r_align_err;
  assign BusErr    = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic        ByteAcc;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AlignErr;
  logic        BusErr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_tests;
  int n_fail;

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .ByteAcc(ByteAcc),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .AlignErr(AlignErr), .BusErr(BusErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ByteAcc   = 1'b0;
    Addr      = 32'd0;
    WriteData = 32'd0;
    mem_rdata = 32'd0;
    mem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({mem_req, mem_we, mem_be, Stall, AlignErr, BusErr} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req=%b we=%b be=%b stall=%b ae=%b be=%b, expected all 0",
               mem_req, mem_we, mem_be, Stall, AlignErr, BusErr);
    end
    n_tests++;
    if ({mem_addr, mem_wdata, ReadData} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, expected 0", mem_addr, mem_wdata, ReadData);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_load();
    Addr = 32'h100; MemRead = 1'b1;
    #1;
    n_tests++;
    if (Stall !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wl_idle_stall: got stall=%b req=%b, expected 1/0", Stall, mem_req);
    end
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || Stall !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1111 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wl_req: got req=%b stall=%b addr=%h be=%b we=%b, expected 1 1 00000100 1111 0",
               mem_req, Stall, mem_addr, mem_be, mem_we);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++;
    if (Stall !== 1'b0 || mem_req !== 1'b0 || ReadData !== 32'hDEADBEEF || BusErr !== 1'b0) begin
      n_fail++;
      $display("FAIL wl_done: got stall=%b req=%b rdata=%h buserr=%b, expected 0 0 deadbeef 0",
               Stall, mem_req, ReadData, BusErr);
    end
    // request still held through DONE must not be re-issued
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wl_no_reissue: got req=%b, expected 0", mem_req);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_byte_store();
    Addr = 32'h203; WriteData = 32'h12345678; ByteAcc = 1'b1; MemWrite = 1'b1;
    @(negedge clk);
    n_tests++;
    if (mem_be !== 4'b1000 || mem_wdata !== 32'h78787878 || mem_addr !== 32'h200 || mem_we !== 1'b1 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL bs_req: got be=%b wdata=%h addr=%h we=%b req=%b, expected 1000 78787878 00000200 1 1",
               mem_be, mem_wdata, mem_addr, mem_we, mem_req);
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    n_tests++;
    if (ReadData !== 32'd0 || Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL bs_done: got rdata=%h stall=%b, expected 00000000 0", ReadData, Stall);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_byte_load();
    Addr = 32'h101; ByteAcc = 1'b1; MemRead = 1'b1;
    @(negedge clk);
    n_tests++;
    if (mem_be !== 4'b0010 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL bl_req: got be=%b addr=%h we=%b, expected 0010 00000100 0", mem_be, mem_addr, mem_we);
    end
    mem_ack = 1'b1; mem_rdata = 32'hAABBCCDD;
    @(negedge clk);
    n_tests++;
    if (ReadData !== 32'h000000CC) begin
      n_fail++;
      $display("FAIL bl_data: got %h expected 000000cc", ReadData);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_read_write_both();
    Addr = 32'h40; WriteData = 32'hCAFEF00D; MemRead = 1'b1; MemWrite = 1'b1;
    @(negedge clk);
    n_tests++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hCAFEF00D || mem_be !== 4'b1111) begin
      n_fail++;
      $display("FAIL rw_req: got we=%b wdata=%h be=%b, expected 1 cafef00d 1111", mem_we, mem_wdata, mem_be);
    end
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    n_tests++;
    if (ReadData !== 32'd0) begin
      n_fail++;
      $display("FAIL rw_rdata: got %h expected 00000000", ReadData);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_pre_timeout_data();
    // leaves a nonzero ReadData so the timeout's zeroing is observable
    Addr = 32'h300; MemRead = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    n_tests++;
    if (ReadData !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL pt_data: got %h expected 0badf00d", ReadData);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int req_cycles;
    bit ended;
    req_cycles = 0;
    ended = 1'b0;
    Addr = 32'h300; MemRead = 1'b1;
    for (int i = 0; i < 40 && !ended; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) req_cycles++;
      else ended = 1'b1;
    end
    n_tests++;
    if (!ended || req_cycles != 15) begin
      n_fail++;
      $display("FAIL to_req_cycles: got %0d (ended=%0d) expected 15", req_cycles, ended);
    end
    n_tests++;
    if (BusErr !== 1'b1 || ReadData !== 32'd0 || Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL to_done: got buserr=%b rdata=%h stall=%b, expected 1 00000000 0", BusErr, ReadData, Stall);
    end
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (BusErr !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL to_idle: got buserr=%b req=%b, expected 0 0", BusErr, mem_req);
    end
  endtask

  task automatic test_ack_at_timeout();
    Addr = 32'h500; MemRead = 1'b1;
    repeat (15) @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL at_last_req: got req=%b expected 1", mem_req);
    end
    mem_ack = 1'b1; mem_rdata = 32'h000055AA;
    @(negedge clk);
    n_tests++;
    if (BusErr !== 1'b0 || ReadData !== 32'h000055AA || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL at_prio: got buserr=%b rdata=%h req=%b, expected 0 000055aa 0", BusErr, ReadData, mem_req);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    Addr = 32'h102; MemRead = 1'b1;
    #1;
    n_tests++;
    if (Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL ma_stall: got %b expected 0", Stall);
    end
    @(negedge clk);
    n_tests++;
    if (AlignErr !== 1'b1 || mem_req !== 1'b0 || ReadData !== 32'd0) begin
      n_fail++;
      $display("FAIL ma_pulse: got ae=%b req=%b rdata=%h, expected 1 0 00000000", AlignErr, mem_req, ReadData);
    end
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (AlignErr !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ma_after: got ae=%b req=%b, expected 0 0", AlignErr, mem_req);
    end
  endtask

  task automatic test_reset_mid_req();
    Addr = 32'h600; MemRead = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_in_req: got req=%b expected 1", mem_req);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_async: got req=%b stall=%b, expected 0 0", mem_req, Stall);
    end
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b0 || Stall !== 1'b0 || mem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL rm_stays_idle: got req=%b stall=%b addr=%h, expected 0 0 00000000", mem_req, Stall, mem_addr);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    clear_inputs();
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_read_write_both();
    test_pre_timeout_data();
    test_timeout();
    test_ack_at_timeout();
    test_misaligned();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, which is the maximum number of REQ cycles to wait for mem_ack before aborting.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port MemRead, input, 1 bit: load request from control.
REQ-005 SHALL have port MemWrite, input, 1 bit: store request from control.
REQ-006 SHALL have port ByteAcc, input, 1 bit: 1 selects byte access (LDRB/STRB), 0 selects word access.
REQ-007 SHALL have port Addr, input, 32 bits: byte address, taken from the datapath ALU result.
REQ-008 SHALL have port WriteData, input, 32 bits: store data from the datapath.
REQ-009 SHALL have port ReadData, output, 32 bits: load data returned to the datapath result mux.
REQ-010 SHALL have port Stall, output, 1 bit: 1 freezes the PC and register writes of the core.
REQ-011 SHALL have port AlignErr, output, 1 bit: one-cycle pulse for a misaligned word access.
REQ-012 SHALL have port BusErr, output, 1 bit: one-cycle pulse on access timeout.
REQ-013 SHALL have port mem_req, output, 1 bit: memory request, held until acknowledged or aborted.
REQ-014 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-015 SHALL have port mem_addr, output, 32 bits: word address to memory, with bits [1:0] forced to 0.
REQ-016 SHALL have port mem_wdata, output, 32 bits: write data to memory.
REQ-017 SHALL have port mem_be, output, 4 bits: byte lane enables.
REQ-018 SHALL have port mem_rdata, input, 32 bits: read data from memory.
REQ-019 SHALL have port mem_ack, input, 1 bit: memory completion strobe.

Function
REQ-020 SHALL implement a 3-state FSM with states IDLE, REQ and DONE.
REQ-021 SHALL, in IDLE with MemRead|MemWrite=1 and the access aligned, drive Stall=1 combinationally in that same cycle, latch mem_addr/mem_we/mem_be/mem_wdata, and go to REQ.
REQ-022 SHALL treat MemRead=MemWrite=1 as a write; ReadData=0 for that access.
REQ-023 SHALL, in REQ, drive mem_req=1 and Stall=1, and hold all mem_* outputs stable until exit.
REQ-024 SHALL, in REQ with mem_ack=1, capture the formatted read data and go to DONE.
REQ-025 SHALL, in REQ, count cycles without ack starting from 0 on REQ entry; at count=TIMEOUT-1 with no ack, go to DONE with BusErr pending and ReadData=0.
REQ-026 SHALL give ack priority when ack and timeout occur in the same cycle (no BusErr).
REQ-027 SHALL, in DONE, drive Stall=0, mem_req=0, ReadData valid, and BusErr=1 if pending; next state is always IDLE, and a request still present in DONE is not re-issued.
REQ-028 SHALL ignore mem_ack in IDLE and in DONE.
REQ-029 SHALL give minimum access latency as: Stall high 2 cycles (IDLE + one REQ), then DONE; each extra REQ cycle adds 1.
REQ-030 SHALL, for byte access (little-endian, lane=Addr[1:0]), set mem_be=1<<lane and mem_wdata={4{WriteData[7:0]}}, and return the read as zero-extended mem_rdata[8*lane+7:8*lane].
REQ-031 SHALL, for word access, set mem_be=4'b1111 and mem_wdata=WriteData, and return ReadData=mem_rdata.
REQ-032 SHALL, for a word access with Addr[1:0]!=0, issue no memory transaction, pulse AlignErr=1 for one cycle while staying in IDLE, drive Stall=0 and ReadData=0.
REQ-033 SHALL hold ReadData at its last value outside DONE; it is guaranteed valid only in DONE.

Reset
REQ-034 SHALL, while reset=0, asynchronously force state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, ReadData=0, AlignErr=0, BusErr=0, timeout count=0, and Stall=0.
REQ-035 SHALL, on reset assertion mid-access (REQ or DONE), drop mem_req immediately, and SHALL NOT resume the aborted access.

Verification
REQ-036 Word load: Addr=0x100, MemRead=1, ack in the first REQ cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111, Stall 1,1,0, ReadData=0xDEADBEEF in DONE.
REQ-037 Byte store: Addr=0x203, WriteData=0x12345678, ByteAcc=1 -> mem_be=1000, mem_wdata=0x78787878, mem_addr=0x200, mem_we=1.
REQ-038 Byte load: Addr=0x101, mem_rdata=0xAABBCCDD -> ReadData=0x000000CC.
REQ-039 Timeout: TIMEOUT=15, mem_ack never asserted -> mem_req high exactly 15 cycles, then DONE with BusErr=1 and ReadData=0, then IDLE.
REQ-040 Misaligned word: Addr=0x102, MemRead=1 -> AlignErr=1 for one cycle, mem_req never 1, Stall=0.
REQ-041 Reset mid-REQ: reset=0 on the third REQ cycle -> mem_req=0 and Stall=0 with no clock edge; after release with no request, FSM stays in IDLE.
